// File: rtl/cpu_pkg.sv
// ============================================================================
//  Module      : cpu_pkg
//  Description : Write-back select codes and trace record type shared by the
//                write-back stage and its trace buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam logic [1:0] WD_SEL_ALU  = 2'd0;
  localparam logic [1:0] WD_SEL_DM   = 2'd1;
  localparam logic [1:0] WD_SEL_PC8  = 2'd2;
  localparam logic [1:0] WD_SEL_ZERO = 2'd3;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  wa;
    logic [31:0] wd;
  } trace_t;

endpackage

`default_nettype wire

// File: rtl/wb_grf_if.sv
// ============================================================================
//  Module      : wb_grf_if
//  Description : Trace drain handshake between the write-back stage (master)
//                and a trace consumer (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface wb_grf_if;

  logic        tr_valid;
  logic        tr_ready;
  logic [31:0] tr_pc;
  logic [4:0]  tr_wa;
  logic [31:0] tr_wd;
  logic        tr_overflow;

  modport master (
    output tr_valid, tr_pc, tr_wa, tr_wd, tr_overflow,
    input  tr_ready
  );

  modport slave (
    input  tr_valid, tr_pc, tr_wa, tr_wd, tr_overflow,
    output tr_ready
  );

endinterface

`default_nettype wire

// File: rtl/wb_trace_fifo.sv
// ============================================================================
//  Module      : wb_trace_fifo
//  Description : Trace record FIFO; drops pushes when full without a pop and
//                flags the drop with a sticky overflow bit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_trace_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wire logic   clk,
  input  wire logic   rst,
  input  wire logic   i_push,
  input  wire trace_t i_data,
  input  wire logic   i_ready,
  output trace_t      o_data,
  output logic        o_valid,
  output logic        o_overflow
);

  localparam int AW = $clog2(DEPTH);

  trace_t        r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic          r_overflow;

  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push_ok;

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop     = i_ready && !w_empty;
  // A pop in the same cycle frees the slot the push needs.
  assign w_push_ok = i_push && (!w_full || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      if (i_push && !w_push_ok) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  assign o_valid    = !w_empty;
  assign o_data     = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign o_overflow = r_overflow;

endmodule

`default_nettype wire

// File: rtl/wb_grf.sv
// ============================================================================
//  Module      : wb_grf
//  Description : Write-back stage: data select, 32x32 register file with
//                W->D bypass, committed-write counter and trace buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_grf
  import cpu_pkg::*;
#(
  parameter int TRACE_DEPTH = 4
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic [31:0] W_PC,
  input  wire logic [31:0] W_ALURes,
  input  wire logic [31:0] W_DM_RD,
  input  wire logic        W_Reg_WE,
  input  wire logic [4:0]  W_Reg_WA,
  input  wire logic [1:0]  W_Reg_WD_sel,
  input  wire logic [4:0]  D_RA1,
  input  wire logic [4:0]  D_RA2,
  output logic      [31:0] D_RD1,
  output logic      [31:0] D_RD2,
  output logic      [31:0] wr_count,
  wb_grf_if.master         tr
);

  logic [31:0] r_grf [32];
  logic [31:0] r_wr_count;
  logic [31:0] w_wd;
  logic        w_commit;
  trace_t      w_push_rec;
  trace_t      w_head;

  always_comb begin
    w_wd = 32'h0;
    case (W_Reg_WD_sel)
      WD_SEL_ALU: w_wd = W_ALURes;
      WD_SEL_DM:  w_wd = W_DM_RD;
      WD_SEL_PC8: w_wd = W_PC + 32'd8;
      default:    w_wd = 32'h0;
    endcase
  end

  // Gating with rst keeps the bypass from leaking data while reset is held.
  assign w_commit = W_Reg_WE && (W_Reg_WA != 5'd0) && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) r_grf[i] <= 32'h0;
      r_wr_count <= 32'h0;
    end else if (w_commit) begin
      r_grf[W_Reg_WA] <= w_wd;
      r_wr_count      <= r_wr_count + 32'd1;
    end
  end

  assign D_RD1 = (D_RA1 == 5'd0) ? 32'h0 :
                 (w_commit && D_RA1 == W_Reg_WA) ? w_wd : r_grf[D_RA1];
  assign D_RD2 = (D_RA2 == 5'd0) ? 32'h0 :
                 (w_commit && D_RA2 == W_Reg_WA) ? w_wd : r_grf[D_RA2];
  assign wr_count = r_wr_count;

  assign w_push_rec = '{pc: W_PC, wa: W_Reg_WA, wd: w_wd};

  wb_trace_fifo #(
    .DEPTH (TRACE_DEPTH)
  ) u_trace_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_commit),
    .i_data     (w_push_rec),
    .i_ready    (tr.tr_ready),
    .o_data     (w_head),
    .o_valid    (tr.tr_valid),
    .o_overflow (tr.tr_overflow)
  );

  assign tr.tr_pc = w_head.pc;
  assign tr.tr_wa = w_head.wa;
  assign tr.tr_wd = w_head.wd;

endmodule

`default_nettype wire

// File: tb/tb_wb_grf.sv
// ============================================================================
//  Module      : tb_wb_grf
//  Description : Self-checking bench for wb_grf with a trace scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_grf;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] W_PC = '0, W_ALURes = '0, W_DM_RD = '0;
  logic        W_Reg_WE = 1'b0;
  logic [4:0]  W_Reg_WA = '0, D_RA1 = '0, D_RA2 = '0;
  logic [1:0]  W_Reg_WD_sel = '0;
  logic [31:0] D_RD1, D_RD2, wr_count;

  int n_vec = 0;
  int n_err = 0;
  trace_t exp_q[$];

  wb_grf_if tr_if ();

  wb_grf #(.TRACE_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .W_PC(W_PC), .W_ALURes(W_ALURes), .W_DM_RD(W_DM_RD),
    .W_Reg_WE(W_Reg_WE), .W_Reg_WA(W_Reg_WA), .W_Reg_WD_sel(W_Reg_WD_sel),
    .D_RA1(D_RA1), .D_RA2(D_RA2), .D_RD1(D_RD1), .D_RD2(D_RD2),
    .wr_count(wr_count), .tr(tr_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic commit(input logic [4:0] wa, input logic [1:0] sel,
                        input logic [31:0] pc, input logic [31:0] val);
    W_Reg_WE = 1'b1; W_Reg_WA = wa; W_Reg_WD_sel = sel;
    W_PC = pc; W_ALURes = val; W_DM_RD = val;
  endtask

  // Monitor: every accepted head entry is compared against the scoreboard.
  always @(negedge clk) begin
    if (!rst && tr_if.tr_valid && tr_if.tr_ready) begin
      if (exp_q.size() == 0) begin
        chk("trace_unexpected", 32'd1, 32'd0);
      end else begin
        trace_t e;
        e = exp_q.pop_front();
        chk("trace_pc", tr_if.tr_pc, e.pc);
        chk("trace_wa", {27'd0, tr_if.tr_wa}, {27'd0, e.wa});
        chk("trace_wd", tr_if.tr_wd, e.wd);
      end
    end
  end

  initial begin
    tr_if.tr_ready = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    step();

    // Reset state: all registers read zero on both ports
    for (int i = 0; i < 16; i++) begin
      D_RA1 = 5'(i); D_RA2 = 5'(31 - i);
      #1;
      chk("reset_rd1", D_RD1, 32'h0);
      chk("reset_rd2", D_RD2, 32'h0);
    end
    chk("reset_wr_count", wr_count, 32'd0);
    chk("reset_tr_valid", {31'd0, tr_if.tr_valid}, 32'd0);
    chk("reset_overflow", {31'd0, tr_if.tr_overflow}, 32'd0);

    // ALU write to $5 with same-cycle bypass
    commit(5'd5, WD_SEL_ALU, 32'h0000_0100, 32'hDEAD_BEEF);
    D_RA1 = 5'd5; D_RA2 = 5'd6;
    #1;
    chk("bypass_rd1", D_RD1, 32'hDEAD_BEEF);
    chk("bypass_rd2_other", D_RD2, 32'h0);
    chk("trace_not_yet_valid", {31'd0, tr_if.tr_valid}, 32'd0);
    exp_q.push_back('{pc: 32'h100, wa: 5'd5, wd: 32'hDEAD_BEEF});
    step();
    W_Reg_WE = 1'b0;
    #1;
    chk("array_rd1", D_RD1, 32'hDEAD_BEEF);
    chk("trace_valid_next", {31'd0, tr_if.tr_valid}, 32'd1);
    chk("wr_count_1", wr_count, 32'd1);
    tr_if.tr_ready = 1'b1;
    step();
    tr_if.tr_ready = 1'b0;

    // Write to $0 is discarded
    commit(5'd0, WD_SEL_DM, 32'h0000_0104, 32'h0000_1234);
    D_RA1 = 5'd0;
    #1;
    chk("zero_reg_rd", D_RD1, 32'h0);
    step();
    W_Reg_WE = 1'b0;
    #1;
    chk("zero_reg_count", wr_count, 32'd1);
    chk("zero_reg_no_trace", {31'd0, tr_if.tr_valid}, 32'd0);

    // Link write PC+8 to $31, then select 3 writes zero over $5
    commit(5'd31, WD_SEL_PC8, 32'h0000_3000, 32'h5555_5555);
    D_RA2 = 5'd31;
    #1;
    chk("link_bypass", D_RD2, 32'h0000_3008);
    exp_q.push_back('{pc: 32'h3000, wa: 5'd31, wd: 32'h3008});
    step();
    commit(5'd5, WD_SEL_ZERO, 32'h0000_3004, 32'h7777_7777);
    D_RA1 = 5'd5;
    #1;
    chk("link_array", D_RD2, 32'h0000_3008);
    chk("sel3_bypass", D_RD1, 32'h0);
    exp_q.push_back('{pc: 32'h3004, wa: 5'd5, wd: 32'h0});
    step();
    W_Reg_WE = 1'b0;
    tr_if.tr_ready = 1'b1;
    repeat (2) step();
    tr_if.tr_ready = 1'b0;
    chk("wr_count_3", wr_count, 32'd3);

    // Six commits into a four-deep buffer with no consumer
    for (int i = 1; i <= 6; i++) begin
      commit(5'(i), WD_SEL_ALU, 32'h4000 + 32'(i * 4), 32'h11 * 32'(i));
      if (i <= 4)
        exp_q.push_back('{pc: 32'h4000 + 32'(i * 4), wa: 5'(i), wd: 32'h11 * 32'(i)});
      step();
    end
    W_Reg_WE = 1'b0;
    D_RA1 = 5'd6;
    #1;
    chk("ovf_flag", {31'd0, tr_if.tr_overflow}, 32'd1);
    chk("ovf_wr_count", wr_count, 32'd9);
    chk("ovf_dropped_still_written", D_RD1, 32'h66);
    tr_if.tr_ready = 1'b1;
    repeat (4) step();
    chk("drain_empty", {31'd0, tr_if.tr_valid}, 32'd0);
    chk("drain_sb_empty", 32'(exp_q.size()), 32'd0);
    tr_if.tr_ready = 1'b0;

    // Full buffer with a concurrent pop accepts the push
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      commit(5'(8 + i), WD_SEL_ALU, 32'h5000 + 32'(i * 4), 32'hA0 + 32'(i));
      exp_q.push_back('{pc: 32'h5000 + 32'(i * 4), wa: 5'(8 + i), wd: 32'hA0 + 32'(i)});
      step();
    end
    commit(5'd12, WD_SEL_ALU, 32'h5010, 32'hA4);
    exp_q.push_back('{pc: 32'h5010, wa: 5'd12, wd: 32'hA4});
    tr_if.tr_ready = 1'b1;
    step();
    W_Reg_WE = 1'b0;
    tr_if.tr_ready = 1'b0;
    #1;
    chk("full_pop_no_ovf", {31'd0, tr_if.tr_overflow}, 32'd0);
    chk("full_pop_head", tr_if.tr_wd, 32'hA1);
    chk("full_pop_count", wr_count, 32'd5);
    tr_if.tr_ready = 1'b1;
    repeat (2) step();

    // Asynchronous reset mid-drain
    #1;
    commit(5'd8, WD_SEL_ALU, 32'h6000, 32'hFFFF_0000);
    D_RA1 = 5'd8;
    rst = 1'b1;
    #1;
    exp_q.delete();
    chk("async_rst_valid", {31'd0, tr_if.tr_valid}, 32'd0);
    chk("async_rst_count", wr_count, 32'd0);
    chk("async_rst_rd", D_RD1, 32'h0);
    chk("async_rst_tr_wd", tr_if.tr_wd, 32'h0);
    W_Reg_WE = 1'b0;
    step();
    rst = 1'b0;
    step();
    chk("post_rst_valid", {31'd0, tr_if.tr_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
